regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between N_REQ writeback sources (ALU, load unit, debug).
//  Uses a round-robin valid/ready arbiter.
//  Keeps a busy scoreboard: one bit per register, set on reservation at issue, cleared when that register's writeback is accepted.
//  Sits between the execute/writeback stages and the register file; drives its w_en/w_add/w_data.
// PARAMETERS
//  N_REQ   3   number of writeback requesters (2..8)
//  ADDR_W  5   register address width; scoreboard has 2**ADDR_W bits
//  DATA_W  32  write data width
// PORTS
//  clk        in   1             clock, all state on posedge
//  rst        in   1             reset, asynchronous, active-low
//  req_valid  in   N_REQ         per-requester writeback request
//  req_addr   in   N_REQ*ADDR_W  destination address, requester i at [i*ADDR_W +: ADDR_W]
//  req_data   in   N_REQ*DATA_W  write data, requester i at [i*DATA_W +: DATA_W]
//  req_ready  out  N_REQ         one-hot grant; transfer when req_valid[i] & req_ready[i]
//  rsv_en     in   1             reserve a destination register (issue stage)
//  rsv_add    in   ADDR_W        register to reserve
//  rsv_stall  out  1             reservation refused; issue must hold and retry
//  busy       out  2**ADDR_W     scoreboard, bit k = register k has a pending write
//  w_en       out  1             register-file write enable
//  w_add      out  ADDR_W        register-file write address
//  w_data     out  DATA_W        register-file write data
// BEHAVIOUR
//  Reset (rst=0, async)
//   - w_en=0, w_add=0, w_data=0, busy=0, ptr=0.
//   - Reset mid-transfer discards the transfer; no write is issued after reset releases.
//  Arbitration (combinational from req_valid and ptr)
//   - Search starts at index ptr and increments mod N_REQ.
//   - The first valid index gets req_ready; at most one bit set.
//   - req_ready=0 for all requesters when none is valid.
//   - On a transfer from index i: ptr <= (i+1) mod N_REQ. No transfer: ptr holds.
//   - A requester must hold valid/addr/data stable until ready. The arbiter never stalls a lone requester.
//  Write port (registered, 1-cycle latency)
//   - Transfer in cycle t -> w_en=1 with w_add/w_data of the winner in cycle t+1.
//   - Otherwise w_en=0; w_add/w_data hold their last value.
//   - Sustained throughput is one write per cycle.
//   - Writes to address 0 are accepted (ready given, ptr advances) but w_en stays 0.
//  Scoreboard
//   - set  = rsv_en & (rsv_add!=0) & ~rsv_stall -> busy[rsv_add] <= 1 next cycle.
//   - clr  = transfer with req_addr!=0 -> busy[req_addr] <= 0 next cycle.
//   - rsv_stall = rsv_en & busy[rsv_add] & ~(clr to the same address this cycle); combinational.
//   - Set and clr to the same address in one cycle: busy stays 1, no stall.
//     (Old write retires; new one is reserved.)
//   - Set and clr to different addresses in one cycle: both take effect.
//   - busy[0] is constant 0. rsv_add=0 never stalls and never sets.
//   - A writeback to a non-busy register is legal: it is written, and busy stays 0.
//  State: ptr ($clog2(N_REQ) bits), busy register, w_* output registers. No other FSM.
// TESTING
//  1. Hold rst=0, drive random inputs -> w_en=0, w_add=0, w_data=0, busy=0, req_ready follows arbitration from ptr=0.
//  2. Release reset; req_valid=3'b010, addr=5, data=0xDEADBEEF -> req_ready=3'b010 same cycle.
//     Next cycle: w_en=1, w_add=5, w_data=0xDEADBEEF. Cycle after that: w_en=0.
//  3. req_valid=3'b111 held 4 cycles from ptr=0 -> grants 001,010,100,001.
//     w_en=1 for 4 consecutive cycles, each one cycle after its grant.
//  4. Scoreboard sequence:
//     - rsv 7 -> busy[7]=1.
//     - rsv 7 again -> rsv_stall=1, busy unchanged.
//     - rsv 7 in the same cycle as writeback addr 7 -> no stall, busy[7] stays 1.
//     - Writeback 7 alone -> busy[7]=0 next cycle.
//  5. Writeback addr 0, data 0x1234 -> req_ready=1, ptr advances, w_en stays 0.
//     rsv_en with rsv_add=0 -> rsv_stall=0, busy[0]=0.
//  6. Assert rst during the cycle after a grant (w_en=1) -> w_en, busy and ptr go to 0 immediately.
//     No write after release; the next grant starts from requester 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between N_REQ writeback sources.
// It also keeps a per-register busy scoreboard that issue checks before reserving a destination.
module regfile_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      rsv_en,
  input  logic [ADDR_W-1:0]         rsv_add,
  output logic                      rsv_stall,
  output logic [2**ADDR_W-1:0]      busy,
  output logic                      w_en,
  output logic [ADDR_W-1:0]         w_add,
  output logic [DATA_W-1:0]         w_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int N_REG = 2**ADDR_W;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [N_REG-1:0]  busy_q, busy_d;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] w_add_q, w_add_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;

  logic              hi_any;
  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              xfer;
  logic              clr_en;
  logic              set_en;

  // Prefer the lowest valid index at or above ptr; if none, wrap to the lowest valid overall.
  always_comb begin
    hi_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && (ptr_q <= PTR_W'(i))) hi_any = 1'b1;
    end
    grant    = '0;
    win_idx  = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (!hi_any || (ptr_q <= PTR_W'(i)))) begin
        grant    = '0;
        grant[i] = 1'b1;
        win_idx  = PTR_W'(i);
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign xfer   = |grant;
  assign clr_en = xfer && (win_addr != '0);

  // A same-cycle retirement of the reserved register frees it, so the reservation goes through.
  always_comb begin
    rsv_stall = rsv_en && busy_q[rsv_add] && !(clr_en && (win_addr == rsv_add));
    set_en    = rsv_en && (rsv_add != '0) && !rsv_stall;
    busy_d    = busy_q;
    if (clr_en) busy_d[win_addr] = 1'b0;
    if (set_en) busy_d[rsv_add]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    ptr_d    = ptr_q;
    w_en_d   = clr_en;
    w_add_d  = w_add_q;
    w_data_d = w_data_q;
    if (xfer) ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    if (clr_en) begin
      w_add_d  = win_addr;
      w_data_d = win_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= '0;
      busy_q   <= '0;
      w_en_q   <= 1'b0;
      w_add_q  <= '0;
      w_data_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      w_en_q   <= w_en_d;
      w_add_q  <= w_add_d;
      w_data_q <= w_data_d;
    end
  end

  assign req_ready = grant;
  assign busy      = busy_q;
  assign w_en      = w_en_q;
  assign w_add     = w_add_q;
  assign w_data    = w_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset corner cases,
// and a randomized run against a round-robin/scoreboard reference model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  reqValid;
  logic [14:0] reqAddr;
  logic [95:0] reqData;
  logic [2:0]  reqReady;
  logic        rsvEn;
  logic [4:0]  rsvAdd;
  logic        rsvStall;
  logic [31:0] busy;
  logic        wEn;
  logic [4:0]  wAdd;
  logic [31:0] wData;

  int testsRun;
  int testsFailed;

  regfile_wb_arbiter #(.N_REQ(3), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_addr(reqAddr), .req_data(reqData), .req_ready(reqReady),
    .rsv_en(rsvEn), .rsv_add(rsvAdd), .rsv_stall(rsvStall), .busy(busy),
    .w_en(wEn), .w_add(wAdd), .w_data(wData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic        rsvEn;
    logic [4:0]  rsvAdd;
    logic [2:0]  expReady;
    logic        expStall;
    logic        expWen;
    logic [4:0]  expWadd;
    logic [31:0] expWdata;
    logic [31:0] expBusy;
  } vec_t;

  vec_t vec [16];

  // Reference model state: ptr as a plain integer, busy as a bit array.
  int          mPtr;
  logic [31:0] mBusy;
  logic        mWen;
  logic [4:0]  mWadd;
  logic [31:0] mWdata;
  logic [2:0]  expReady;
  logic        expStall;

  function automatic vec_t mkVec(logic [2:0] v, logic [4:0] a2, logic [4:0] a1, logic [4:0] a0,
                                 logic [31:0] d2, logic [31:0] d1, logic [31:0] d0,
                                 logic re, logic [4:0] ra, logic [2:0] er, logic es,
                                 logic ew, logic [4:0] ewa, logic [31:0] ewd, logic [31:0] eb);
    vec_t t;
    t.valid = v; t.addr = {a2, a1, a0}; t.data = {d2, d1, d0};
    t.rsvEn = re; t.rsvAdd = ra; t.expReady = er; t.expStall = es;
    t.expWen = ew; t.expWadd = ewa; t.expWdata = ewd; t.expBusy = eb;
    return t;
  endfunction

  function automatic int firstFrom(logic [2:0] v, int p);
    for (int k = 0; k < 3; k++) begin
      if (v[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                               input logic re, input logic [4:0] ra);
    @(negedge clk);
    reqValid = v;
    reqAddr  = a;
    reqData  = d;
    rsvEn    = re;
    rsvAdd   = ra;
  endtask

  task automatic modelReset();
    mPtr = 0; mBusy = '0; mWen = 1'b0; mWadd = '0; mWdata = '0;
  endtask

  // One clock of the reference: expected combinational outputs, then next state.
  task automatic modelStep(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                           input logic re, input logic [4:0] ra);
    int win;
    logic [4:0] ca;
    logic clr;
    win = firstFrom(v, mPtr);
    expReady = (win >= 0) ? 3'(1 << win) : 3'b000;
    ca  = (win >= 0) ? a[win*5 +: 5] : 5'd0;
    clr = (win >= 0) && (ca != 0);
    expStall = re && mBusy[ra] && !(clr && (ca == ra));
    if (win >= 0) mPtr = (win + 1) % 3;
    mWen = clr;
    if (clr) begin
      mWadd  = ca;
      mWdata = d[win*32 +: 32];
      mBusy[ca] = 1'b0;
    end
    if (re && (ra != 0) && !expStall) mBusy[ra] = 1'b1;
  endtask

  task automatic checkRegs(input string tag, input logic ew, input logic [4:0] ewa,
                           input logic [31:0] ewd, input logic [31:0] eb);
    checkOutput({tag, " w_en"}, 32'(wEn), 32'(ew));
    checkOutput({tag, " w_add"}, 32'(wAdd), 32'(ewa));
    checkOutput({tag, " w_data"}, wData, ewd);
    checkOutput({tag, " busy"}, busy, eb);
  endtask

  initial begin
    logic [2:0]  v;
    logic [2:0]  pv;
    logic [4:0]  pa [3];
    logic [31:0] pd [3];
    logic [14:0] aBus;
    logic [95:0] dBus;
    testsRun = 0; testsFailed = 0;
    rst = 1'b0; reqValid = '0; reqAddr = '0; reqData = '0; rsvEn = 1'b0; rsvAdd = '0;

    // Directed table; w_*/busy columns are the values after the clock edge of that row.
    vec[0]  = mkVec(3'b010, 0, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 3'b010, 0, 1, 5, 32'hDEADBEEF, 0);
    vec[1]  = mkVec(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 5, 32'hDEADBEEF, 0);
    vec[2]  = mkVec(3'b100, 3, 0, 0, 32'h33, 0, 0, 0, 0, 3'b100, 0, 1, 3, 32'h33, 0);
    vec[3]  = mkVec(3'b111, 12, 11, 10, 32'hC2, 32'hB1, 32'hA0, 0, 0, 3'b001, 0, 1, 10, 32'hA0, 0);
    vec[4]  = mkVec(3'b111, 12, 11, 10, 32'hC2, 32'hB1, 32'hA0, 0, 0, 3'b010, 0, 1, 11, 32'hB1, 0);
    vec[5]  = mkVec(3'b111, 12, 11, 10, 32'hC2, 32'hB1, 32'hA0, 0, 0, 3'b100, 0, 1, 12, 32'hC2, 0);
    vec[6]  = mkVec(3'b111, 12, 11, 10, 32'hC2, 32'hB1, 32'hA0, 0, 0, 3'b001, 0, 1, 10, 32'hA0, 0);
    vec[7]  = mkVec(3'b000, 0, 0, 0, 0, 0, 0, 1, 7, 3'b000, 0, 0, 10, 32'hA0, 32'h80);
    vec[8]  = mkVec(3'b000, 0, 0, 0, 0, 0, 0, 1, 7, 3'b000, 1, 0, 10, 32'hA0, 32'h80);
    vec[9]  = mkVec(3'b001, 0, 0, 7, 0, 0, 32'h77, 1, 7, 3'b001, 0, 1, 7, 32'h77, 32'h80);
    vec[10] = mkVec(3'b010, 0, 7, 0, 0, 32'h78, 0, 0, 0, 3'b010, 0, 1, 7, 32'h78, 0);
    vec[11] = mkVec(3'b100, 7, 0, 0, 32'h79, 0, 0, 1, 9, 3'b100, 0, 1, 7, 32'h79, 32'h200);
    vec[12] = mkVec(3'b001, 0, 0, 9, 0, 0, 32'h99, 1, 20, 3'b001, 0, 1, 9, 32'h99, 32'h100000);
    vec[13] = mkVec(3'b010, 0, 0, 0, 0, 32'h1234, 0, 1, 0, 3'b010, 0, 0, 9, 32'h99, 32'h100000);
    vec[14] = mkVec(3'b011, 0, 2, 1, 0, 32'h22, 32'h11, 0, 0, 3'b001, 0, 1, 1, 32'h11, 32'h100000);
    vec[15] = mkVec(3'b000, 0, 0, 0, 0, 0, 0, 1, 20, 3'b000, 1, 0, 1, 32'h11, 32'h100000);

    // Reset held: outputs cleared, arbitration runs from requester 0.
    for (int c = 0; c < 5; c++) begin
      v = 3'($urandom_range(0, 7));
      applyStimulus(v, 15'($urandom), {$urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)));
      #1;
      checkOutput($sformatf("rst%0d ready", c), 32'(reqReady),
                  (firstFrom(v, 0) >= 0) ? (32'd1 << firstFrom(v, 0)) : 32'd0);
      checkOutput($sformatf("rst%0d stall", c), 32'(rsvStall), 32'd0);
      checkRegs($sformatf("rst%0d", c), 1'b0, 5'd0, 32'd0, 32'd0);
    end
    applyStimulus(3'b000, '0, '0, 1'b0, '0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vec[i].valid, vec[i].addr, vec[i].data, vec[i].rsvEn, vec[i].rsvAdd);
      #1;
      checkOutput($sformatf("vec%0d ready", i), 32'(reqReady), 32'(vec[i].expReady));
      checkOutput($sformatf("vec%0d stall", i), 32'(rsvStall), 32'(vec[i].expStall));
      @(posedge clk); #1;
      checkRegs($sformatf("vec%0d", i), vec[i].expWen, vec[i].expWadd, vec[i].expWdata, vec[i].expBusy);
    end

    // Reset in the cycle after a grant clears everything at once and ptr returns to 0.
    applyStimulus(3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'h55, 32'd0}, 1'b1, 5'd6);
    #1;
    checkOutput("rstmid ready", 32'(reqReady), 32'b010);
    @(posedge clk); #1;
    checkOutput("rstmid w_en before", 32'(wEn), 32'd1);
    reqValid = 3'b000; rsvEn = 1'b0;
    #1 rst = 1'b0;
    #1;
    checkRegs("rstmid async", 1'b0, 5'd0, 32'd0, 32'd0);
    applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 5'd0);
    #1;
    checkOutput("rstmid held ready", 32'(reqReady), 32'b001);
    @(posedge clk); #1;
    checkOutput("rstmid held w_en", 32'(wEn), 32'd0);
    applyStimulus(3'b000, '0, '0, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstmid release w_en", 32'(wEn), 32'd0);
    applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 5'd0);
    #1;
    checkOutput("rstmid first grant", 32'(reqReady), 32'b001);

    // Randomized run; requesters hold their request until granted.
    applyStimulus(3'b000, '0, '0, 1'b0, '0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    pv = 3'b000;
    for (int r = 0; r < 3; r++) begin pa[r] = '0; pd[r] = '0; end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checkRegs($sformatf("rnd%0d", c), mWen, mWadd, mWdata, mBusy);
      for (int r = 0; r < 3; r++) begin
        if (!pv[r]) begin
          pv[r] = 1'($urandom_range(0, 1));
          pa[r] = 5'($urandom_range(0, 7));
          pd[r] = $urandom;
        end
        aBus[r*5 +: 5]   = pa[r];
        dBus[r*32 +: 32] = pd[r];
      end
      reqValid = pv; reqAddr = aBus; reqData = dBus;
      rsvEn  = 1'($urandom_range(0, 1));
      rsvAdd = 5'($urandom_range(0, 7));
      #1;
      modelStep(pv, aBus, dBus, rsvEn, rsvAdd);
      checkOutput($sformatf("rnd%0d ready", c), 32'(reqReady), 32'(expReady));
      checkOutput($sformatf("rnd%0d stall", c), 32'(rsvStall), 32'(expStall));
      pv = pv & ~expReady;
    end
    @(negedge clk);
    checkRegs("rnd end", mWen, mWadd, mWdata, mBusy);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
